fetch_sequencer: RTL

Instruction fetch sequencer for the 16-bit core. It fetches one or two instruction words over the single-port memory bus and holds them stable on IR1/IR2 for the instruction decoder. It then waits for execution to complete, advances or redirects the PC, and halts permanently when the decoder flags an error. It sits between the memory bus master port and the `instruction_decoder` ir inputs.

---
 rtl/fetch_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches one or two words, presents them on ir1/ir2,
// waits for retirement, then advances or redirects the pc. A decoder error halts it until reset.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_ir1,
  output logic [15:0] o_ir2,
  output logic        o_ir_valid,
  output logic [15:0] o_pc,
  input  logic        i_two_word,
  input  logic        i_exec_done,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  input  logic        i_err,
  output logic        o_halted,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_F1   = 3'd0,
    S_LEN  = 3'd1,
    S_F2   = 3'd2,
    S_DISP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir1_q, ir1_d;
  logic [15:0] ir2_q, ir2_d;
  logic        two_word_q, two_word_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_F1;
      pc_q       <= RESET_PC;
      ir1_q      <= 16'h0000;
      ir2_q      <= 16'h0000;
      two_word_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir1_q      <= ir1_d;
      ir2_q      <= ir2_d;
      two_word_q <= two_word_d;
    end
  end

  // Bus handshake: req is held with a stable address until an edge sees ack=1,
  // which completes the read; ack may arrive in the same cycle req first rises.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir1_d      = ir1_q;
    ir2_d      = ir2_q;
    two_word_d = two_word_q;
    case (state_q)
      S_F1: begin
        if (i_mem_ack) begin
          ir1_d   = i_mem_rdata;
          ir2_d   = 16'h0000;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        two_word_d = i_two_word;
        state_d    = i_two_word ? S_F2 : S_DISP;
      end
      S_F2: begin
        if (i_mem_ack) begin
          ir2_d   = i_mem_rdata;
          state_d = S_DISP;
        end
      end
      S_DISP: begin
        // Error outranks retirement so a faulting instruction never moves the pc.
        if (i_err) begin
          state_d = S_HALT;
        end else if (i_exec_done) begin
          pc_d    = i_jump ? i_jump_addr : pc_q + (two_word_q ? 16'd2 : 16'd1);
          state_d = S_F1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_F1;
    endcase
  end

  assign o_mem_req  = (state_q == S_F1) || (state_q == S_F2);
  assign o_mem_addr = (state_q == S_F2) ? pc_q + 16'd1 : pc_q;
  assign o_ir1      = ir1_q;
  assign o_ir2      = ir2_q;
  assign o_ir_valid = (state_q == S_DISP);
  assign o_pc       = pc_q;
  assign o_halted   = (state_q == S_HALT);
  assign o_state    = state_q;

endmodule
